// File: rtl/axis_pkt_rr_arb_pkg.sv
// Shared types and helpers for the packet round-robin arbiters.
package axis_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

  // Next index after idx in a ring of n entries.
  function automatic int unsigned wrapInc(input int unsigned idx, input int unsigned n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/axis_pkt_rr_arb_if.sv
// Bundle of N parallel AXI-stream channels sharing one data bus (channel i at [i*WIDTH +: WIDTH]).
interface axis_pkt_rr_arb_if #(
  parameter int WIDTH = 32,
  parameter int N     = 1
);
  logic [N*WIDTH-1:0] tdata;
  logic [N-1:0]       tvalid;
  logic [N-1:0]       tlast;
  logic [N-1:0]       tready;

  modport master (output tdata, output tvalid, output tlast, input  tready);
  modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/axis_pkt_rr_arb_rr_pick.sv
// Combinational round-robin picker: first asserted req at or after ptr, wrapping at NUM_IN-1.
module rr_pick #(
  parameter int NUM_IN = 4,
  parameter int IDW    = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [IDW-1:0]    ptr,
  output logic [IDW-1:0]    pick,
  output logic              any
);

  function automatic logic [IDW-1:0] rotIdx(input logic [IDW-1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NUM_IN) s -= NUM_IN;
    return s[IDW-1:0];
  endfunction

  // Scan from the farthest offset down so the nearest request to ptr wins.
  always_comb begin
    pick = '0;
    any  = 1'b0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      if (req[rotIdx(ptr, k)]) begin
        pick = rotIdx(ptr, k);
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_pkt_rr_arb.sv
// Packet-level round-robin AXI-stream arbiter: grant locks from arbitration until the granted tlast beat.
module axis_pkt_rr_arb
  import axis_arb_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int IDW    = $clog2(NUM_IN),
  parameter int CNTW   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  axis_pkt_rr_arb_if.slave   s_axis,
  axis_pkt_rr_arb_if.master  m_axis,
  output logic [IDW-1:0]     grant_id,
  output logic               busy,
  output logic [CNTW-1:0]    beat_cnt
);

  arb_state_t r_state;
  arb_state_t w_nextState;

  logic [IDW-1:0]    r_ptr;
  logic [IDW-1:0]    r_grant;
  logic [CNTW-1:0]   r_beat;
  logic [IDW-1:0]    w_pick;
  logic              w_any;
  logic [WIDTH-1:0]  w_gData;
  logic              w_gValid;
  logic              w_gLast;
  logic [NUM_IN-1:0] w_sReady;
  logic              w_mValid;
  logic              w_mLast;
  logic              w_busy;
  logic              w_xfer;

  rr_pick #(
    .NUM_IN (NUM_IN),
    .IDW    (IDW)
  ) u_pick (
    .req  (s_axis.tvalid),
    .ptr  (r_ptr),
    .pick (w_pick),
    .any  (w_any)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ARB_IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ARB_IDLE: if (w_any) w_nextState = ARB_BUSY;
      ARB_BUSY: if (w_xfer && w_mLast) w_nextState = ARB_IDLE;
      default:  w_nextState = ARB_IDLE;
    endcase
  end

  // The data path always follows grant_id; valid/last/ready are gated by BUSY only.
  always_comb begin
    w_gData  = '0;
    w_gValid = 1'b0;
    w_gLast  = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (r_grant == IDW'(i)) begin
        w_gData  = s_axis.tdata[i*WIDTH +: WIDTH];
        w_gValid = s_axis.tvalid[i];
        w_gLast  = s_axis.tlast[i];
      end
    end
  end

  always_comb begin
    w_sReady = '0;
    w_mValid = 1'b0;
    w_mLast  = 1'b0;
    w_busy   = 1'b0;
    if (r_state == ARB_BUSY) begin
      w_busy   = 1'b1;
      w_mValid = w_gValid;
      w_mLast  = w_gLast;
      for (int i = 0; i < NUM_IN; i++) begin
        if (r_grant == IDW'(i)) w_sReady[i] = m_axis.tready[0];
      end
    end
  end

  assign w_xfer = w_mValid & m_axis.tready[0];

  // Finishing input moves to lowest priority; the beat counter saturates rather than wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_grant <= '0;
      r_beat  <= '0;
    end else if (r_state == ARB_IDLE) begin
      if (w_any) begin
        r_grant <= w_pick;
        r_beat  <= '0;
      end
    end else if (w_xfer) begin
      if (r_beat != {CNTW{1'b1}}) r_beat <= r_beat + 1'b1;
      if (w_mLast) r_ptr <= IDW'(wrapInc(32'(r_grant), NUM_IN));
    end
  end

  assign s_axis.tready = w_sReady;
  assign m_axis.tdata  = w_gData;
  assign m_axis.tvalid = w_mValid;
  assign m_axis.tlast  = w_mLast;
  assign grant_id      = r_grant;
  assign busy          = w_busy;
  assign beat_cnt      = r_beat;

endmodule

// File: tb/tb_axis_pkt_rr_arb.sv
// Directed bench for axis_pkt_rr_arb: a 4-input instance plus a 3-input instance for ring wrap.
module tb_axis_pkt_rr_arb;

  localparam int W = 32;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axis_pkt_rr_arb_if #(.WIDTH(W), .N(N)) sIf ();
  axis_pkt_rr_arb_if #(.WIDTH(W), .N(1)) mIf ();
  axis_pkt_rr_arb_if #(.WIDTH(W), .N(3)) s3If ();
  axis_pkt_rr_arb_if #(.WIDTH(W), .N(1)) m3If ();

  logic [1:0]  grantId;
  logic        busy;
  logic [15:0] beatCnt;
  logic [1:0]  grant3;
  logic        busy3;
  logic [15:0] beat3;

  axis_pkt_rr_arb #(.WIDTH(W), .NUM_IN(N), .CNTW(16)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_axis   (sIf),
    .m_axis   (mIf),
    .grant_id (grantId),
    .busy     (busy),
    .beat_cnt (beatCnt)
  );

  axis_pkt_rr_arb #(.WIDTH(W), .NUM_IN(3), .CNTW(16)) u_dut3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_axis   (s3If),
    .m_axis   (m3If),
    .grant_id (grant3),
    .busy     (busy3),
    .beat_cnt (beat3)
  );

  int nChecks = 0;
  int nBad = 0;
  int srcLen[N];
  int srcLeft[N];
  int srcBeat[N];
  logic srcHold[N];

  function automatic logic [31:0] dataOf(input int i, input int b);
    return {8'(i), 8'hA5, 16'(b)};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nBad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Each source emits packets of srcLen beats; data encodes input index and running beat number.
  task automatic driveSources();
    for (int i = 0; i < N; i++) begin
      sIf.tvalid[i] = (srcLeft[i] > 0) && !srcHold[i];
      sIf.tdata[i*W +: W] = dataOf(i, srcBeat[i]);
      sIf.tlast[i] = ((srcBeat[i] % srcLen[i]) == srcLen[i] - 1);
    end
  endtask

  task automatic applyStimulus(input int i, input int len, input int pkts);
    srcLen[i]  = len;
    srcLeft[i] = pkts;
    srcBeat[i] = 0;
    srcHold[i] = 1'b0;
  endtask

  task automatic nextCycle();
    for (int i = 0; i < N; i++) begin
      if (sIf.tvalid[i] && sIf.tready[i]) begin
        if (sIf.tlast[i]) srcLeft[i]--;
        srcBeat[i]++;
      end
    end
    @(posedge clk);
    #1;
    driveSources();
    #2;
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    mIf.tready = 1'b1;
    m3If.tready = 1'b1;
    s3If.tvalid = '0;
    s3If.tlast = '0;
    s3If.tdata = '0;
    for (int i = 0; i < N; i++) applyStimulus(i, 1, 0);
    driveSources();
    nextCycle();
    nextCycle();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int readyPat[6];
    int expBeat3[6];
    int gapPat[10];
    int busy4[9];
    int valid4[9];
    int beat4[9];
    int grant4[9];
    readyPat = '{1, 0, 0, 1, 1, 1};
    expBeat3 = '{0, 1, 1, 1, 2, 3};
    gapPat   = '{0, 0, 1, 1, 1, 0, 0, 0, 0, 0};
    busy4    = '{0, 1, 1, 1, 1, 1, 1, 0, 1};
    valid4   = '{0, 1, 0, 0, 0, 1, 1, 0, 1};
    beat4    = '{0, 0, 1, 1, 1, 1, 2, 3, 0};
    grant4   = '{0, 0, 0, 0, 0, 0, 0, 0, 3};

    // Reset state, then a 3-beat packet from input 2.
    resetDut();
    checkOutput("rst busy", busy, 0);
    checkOutput("rst mvalid", mIf.tvalid, 0);
    checkOutput("rst mlast", mIf.tlast, 0);
    checkOutput("rst sready", sIf.tready, 0);
    checkOutput("rst beat", beatCnt, 0);
    checkOutput("rst grant", grantId, 0);
    applyStimulus(2, 3, 1);
    driveSources();
    #1;
    checkOutput("t1 bubble sready", sIf.tready, 0);
    checkOutput("t1 bubble mvalid", mIf.tvalid, 0);
    nextCycle();
    for (int b = 0; b < 3; b++) begin
      checkOutput("t1 grant", grantId, 2);
      checkOutput("t1 busy", busy, 1);
      checkOutput("t1 data", mIf.tdata, dataOf(2, b));
      checkOutput("t1 last", mIf.tlast, (b == 2));
      checkOutput("t1 beat", beatCnt, b);
      checkOutput("t1 sready", sIf.tready, 4'b0100);
      nextCycle();
    end
    checkOutput("t1 busy end", busy, 0);
    checkOutput("t1 beat final", beatCnt, 3);
    applyStimulus(0, 1, 1);
    applyStimulus(3, 1, 1);
    driveSources();
    nextCycle();
    checkOutput("t1 ptr3 grant", grantId, 3);
    checkOutput("t1 ptr3 beat", beatCnt, 0);
    nextCycle();
    checkOutput("t1 single busy", busy, 0);
    checkOutput("t1 single beat", beatCnt, 1);
    nextCycle();
    checkOutput("t1 wrap grant", grantId, 0);
    nextCycle();

    // All inputs valid with 2-beat packets: grants 0,1,2,3,0 with a bubble each.
    resetDut();
    for (int i = 0; i < N; i++) applyStimulus(i, 2, (i == 0) ? 2 : 1);
    driveSources();
    #1;
    for (int c = 0; c < 15; c++) begin
      int pos;
      int pkt;
      int g;
      pos = c % 3;
      pkt = c / 3;
      g = pkt % 4;
      if (pos == 0) begin
        checkOutput("t2 bubble", mIf.tvalid, 0);
      end else begin
        checkOutput("t2 grant", grantId, g);
        checkOutput("t2 data", mIf.tdata, dataOf(g, (pkt / 4) * 2 + pos - 1));
        checkOutput("t2 last", mIf.tlast, (pos == 2));
        checkOutput("t2 sready", sIf.tready, 64'(1) << g);
      end
      nextCycle();
    end
    checkOutput("t2 drained", busy, 0);

    // Backpressure on a 4-beat packet from input 1 while input 3 waits.
    resetDut();
    applyStimulus(1, 4, 1);
    applyStimulus(3, 1, 1);
    driveSources();
    nextCycle();
    for (int k = 0; k < 6; k++) begin
      mIf.tready = readyPat[k][0];
      #1;
      checkOutput("t3 grant", grantId, 1);
      checkOutput("t3 sready", sIf.tready, (readyPat[k] != 0) ? 4'b0010 : 4'b0000);
      checkOutput("t3 data", mIf.tdata, dataOf(1, expBeat3[k]));
      checkOutput("t3 beat", beatCnt, expBeat3[k]);
      nextCycle();
    end
    checkOutput("t3 beat final", beatCnt, 4);
    checkOutput("t3 busy end", busy, 0);
    nextCycle();
    checkOutput("t3 next grant", grantId, 3);
    nextCycle();

    // Input 0 gaps mid-packet while input 3 requests; grant must hold.
    resetDut();
    applyStimulus(0, 3, 1);
    applyStimulus(3, 1, 1);
    driveSources();
    #1;
    for (int c = 0; c < 9; c++) begin
      checkOutput("t4 busy", busy, busy4[c]);
      checkOutput("t4 mvalid", mIf.tvalid, valid4[c]);
      checkOutput("t4 beat", beatCnt, beat4[c]);
      checkOutput("t4 sready3", sIf.tready[3], (c == 8));
      if (busy4[c] != 0) checkOutput("t4 grant", grantId, grant4[c]);
      srcHold[0] = gapPat[c + 1][0];
      nextCycle();
    end
    nextCycle();

    // Reset during beat 2 of a 5-beat packet; pointer must restart at 0.
    resetDut();
    applyStimulus(2, 1, 1);
    driveSources();
    nextCycle();
    nextCycle();
    checkOutput("t6 pre busy", busy, 0);
    applyStimulus(1, 5, 1);
    driveSources();
    nextCycle();
    checkOutput("t6 grant", grantId, 1);
    nextCycle();
    checkOutput("t6 beat2 data", mIf.tdata, dataOf(1, 1));
    checkOutput("t6 beat2 cnt", beatCnt, 1);
    rst_n = 1'b0;
    nextCycle();
    rst_n = 1'b1;
    checkOutput("t6 rst busy", busy, 0);
    checkOutput("t6 rst sready", sIf.tready, 0);
    checkOutput("t6 rst beat", beatCnt, 0);
    applyStimulus(0, 1, 1);
    applyStimulus(3, 1, 1);
    driveSources();
    nextCycle();
    checkOutput("t6 ptr0 grant", grantId, 0);
    nextCycle();

    // NUM_IN=3 instance: bring ptr to 2, then requests on 0 and 2.
    resetDut();
    s3If.tdata = {dataOf(2, 7), dataOf(1, 7), dataOf(0, 7)};
    s3If.tlast = 3'b111;
    s3If.tvalid = 3'b010;
    #1;
    checkOutput("t5 idle busy", busy3, 0);
    nextCycle();
    checkOutput("t5 grant1", grant3, 1);
    nextCycle();
    s3If.tvalid = 3'b101;
    #1;
    checkOutput("t5 idle2 busy", busy3, 0);
    checkOutput("t5 beat", beat3, 1);
    nextCycle();
    checkOutput("t5 grant2", grant3, 2);
    checkOutput("t5 data2", m3If.tdata, dataOf(2, 7));
    nextCycle();
    s3If.tvalid = 3'b001;
    #1;
    nextCycle();
    checkOutput("t5 wrap grant0", grant3, 0);
    checkOutput("t5 data0", m3If.tdata, dataOf(0, 7));
    checkOutput("t5 grant range", (grant3 <= 2'd2), 1);
    nextCycle();
    s3If.tvalid = 3'b000;
    nextCycle();

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule
